// File: rtl/synth_seq_pkg.sv
// Shared types and field layout for the step sequencer and its envelope.
package synth_seq_pkg;
  localparam int REST_BIT = 16;
  localparam int INC_W    = 16;
  localparam int ENTRY_W  = REST_BIT + 1;
  localparam int AMP_W    = 10;

  typedef enum logic {SEQ_IDLE, SEQ_PLAY} seq_state_e;
  typedef enum logic [1:0] {ENV_OFF, ENV_ATK, ENV_HOLD, ENV_REL} env_state_e;

  typedef struct packed {
    logic             rest;
    logic [INC_W-1:0] inc;
  } entry_t;
endpackage

// File: rtl/synth_seq_envelope.sv
// Linear attack/hold/release amplitude envelope, updated on a free-running strobe.
module seq_envelope import synth_seq_pkg::*; #(
  parameter int ENV_DIV = 4800,
  parameter int ATK_INC = 64,
  parameter int REL_DEC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             gate,
  input  logic [AMP_W-1:0] amp_max,
  output logic [AMP_W-1:0] amp
);
  localparam int DW = $clog2(ENV_DIV + 1);

  logic [DW-1:0] div_cnt;
  logic          strobe, gate_q;
  env_state_e    state, state_d;
  logic [AMP_W-1:0] amp_d;
  logic [AMP_W:0]   amp_x, max_x, up, dn;

  assign strobe = (div_cnt == DW'(ENV_DIV - 1));
  assign amp_x  = {1'b0, amp};
  assign max_x  = {1'b0, amp_max};
  assign up     = amp_x + (AMP_W+1)'(ATK_INC);
  assign dn     = amp_x - (AMP_W+1)'(REL_DEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      gate_q  <= 1'b0;
      state   <= ENV_OFF;
      amp     <= '0;
    end else begin
      div_cnt <= strobe ? '0 : div_cnt + 1'b1;
      gate_q  <= gate;
      state   <= state_d;
      amp     <= amp_d;
    end
  end

  // A rising gate restarts the attack from wherever amp currently sits.
  always_comb begin
    state_d = state;
    amp_d   = amp;
    if (gate && !gate_q) begin
      state_d = ENV_ATK;
    end else begin
      case (state)
        ENV_ATK: begin
          if (!gate) state_d = ENV_REL;
          else if (strobe) begin
            if (up >= max_x) begin
              amp_d   = amp_max;
              state_d = ENV_HOLD;
            end else amp_d = up[AMP_W-1:0];
          end
        end
        ENV_HOLD: begin
          if (!gate) state_d = ENV_REL;
          else if (strobe && amp > amp_max) amp_d = amp_max;
        end
        ENV_REL: begin
          if (strobe) begin
            if (amp_x > (AMP_W+1)'(REL_DEC)) amp_d = dn[AMP_W-1:0];
            else begin
              amp_d   = '0;
              state_d = ENV_OFF;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/synth_sequencer.sv
// Step sequencer: walks a programmable pattern at a fixed tempo, drives gate/phase_inc/amp.
module synth_sequencer import synth_seq_pkg::*; #(
  parameter int CLKSPEED = 48_000_000,
  parameter int STEP_HZ  = 8,
  parameter int STEPS    = 8,
  parameter int ENV_DIV  = 4800,
  parameter int ATK_INC  = 64,
  parameter int REL_DEC  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     wr_en,
  input  logic [$clog2(STEPS)-1:0] wr_addr,
  input  logic [ENTRY_W-1:0]       wr_data,
  input  logic [AMP_W-1:0]         amp_max,
  output logic                     gate,
  output logic [INC_W-1:0]         phase_inc,
  output logic [AMP_W-1:0]         amp,
  output logic [$clog2(STEPS)-1:0] step,
  output logic                     step_pulse,
  output logic                     running
);
  localparam int SW         = $clog2(STEPS);
  localparam int STEP_TICKS = CLKSPEED / STEP_HZ;
  localparam int GATE_TICKS = STEP_TICKS - STEP_TICKS / 4;
  localparam int TW         = $clog2(STEP_TICKS + 1);

  entry_t     pattern [STEPS];
  seq_state_e state, state_d;
  logic [TW-1:0]    tick, tick_d;
  logic [SW-1:0]    step_d, fetch_addr;
  logic [INC_W-1:0] inc_d;
  logic cur_rest, rest_d, running_d, pulse_d, gate_d, latch;
  entry_t fet;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STEPS; i++) pattern[i] <= '{rest: 1'b1, inc: '0};
    end else if (wr_en) begin
      pattern[wr_addr] <= entry_t'(wr_data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEQ_IDLE;
      tick       <= '0;
      step       <= '0;
      cur_rest   <= 1'b1;
      phase_inc  <= '0;
      running    <= 1'b0;
      step_pulse <= 1'b0;
      gate       <= 1'b0;
    end else begin
      state      <= state_d;
      tick       <= tick_d;
      step       <= step_d;
      cur_rest   <= rest_d;
      phase_inc  <= inc_d;
      running    <= running_d;
      step_pulse <= pulse_d;
      gate       <= gate_d;
    end
  end

  // Outputs are registered from next-state values so start at n shows at n+1.
  always_comb begin
    state_d    = state;
    tick_d     = tick;
    step_d     = step;
    rest_d     = cur_rest;
    inc_d      = phase_inc;
    running_d  = running;
    pulse_d    = 1'b0;
    latch      = 1'b0;
    fetch_addr = step + 1'b1;
    if (stop) begin
      running_d = 1'b0;
      state_d   = SEQ_IDLE;
    end else if (start) begin
      fetch_addr = '0;
      step_d     = '0;
      tick_d     = '0;
      running_d  = 1'b1;
      pulse_d    = 1'b1;
      latch      = 1'b1;
      state_d    = SEQ_PLAY;
    end else if (state == SEQ_PLAY) begin
      if (tick == TW'(STEP_TICKS - 1)) begin
        tick_d  = '0;
        step_d  = step + 1'b1;
        pulse_d = 1'b1;
        latch   = 1'b1;
      end else tick_d = tick + 1'b1;
    end
    // A write landing on the entry being fetched is forwarded.
    fet = (wr_en && wr_addr == fetch_addr) ? entry_t'(wr_data) : pattern[fetch_addr];
    if (latch) begin
      rest_d = fet.rest;
      if (!fet.rest) inc_d = fet.inc;
    end
    gate_d = running_d & ~rest_d & (tick_d < TW'(GATE_TICKS));
  end

  seq_envelope #(
    .ENV_DIV (ENV_DIV),
    .ATK_INC (ATK_INC),
    .REL_DEC (REL_DEC)
  ) u_env (
    .clk     (clk),
    .rst_n   (rst_n),
    .gate    (gate),
    .amp_max (amp_max),
    .amp     (amp)
  );
endmodule

// File: tb/tb_synth_sequencer.sv
// Directed bench for synth_sequencer with a 10-clock step and per-clock envelope strobe.
module tb_synth_sequencer;
  logic        clk, rst_n, start, stop, wr_en;
  logic [1:0]  wr_addr;
  logic [16:0] wr_data;
  logic [9:0]  amp_max;
  logic        gate, step_pulse, running;
  logic [15:0] phase_inc;
  logic [9:0]  amp;
  logic [1:0]  step;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int inc_tab [4]  = '{'h100, 'h100, 'h300, 'h400};
  int amp_tab [21] = '{0, 0, 256, 512, 768, 1000, 1000, 1000, 1000, 1000,
                       872, 744, 616, 488, 360, 232, 104, 0, 0, 0, 0};

  synth_sequencer #(
    .CLKSPEED (1000), .STEP_HZ (100), .STEPS (4),
    .ENV_DIV (1), .ATK_INC (256), .REL_DEC (128)
  ) dut (
    .clk (clk), .rst_n (rst_n), .start (start), .stop (stop),
    .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data), .amp_max (amp_max),
    .gate (gate), .phase_inc (phase_inc), .amp (amp), .step (step),
    .step_pulse (step_pulse), .running (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clk_step();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) clk_step();
  endtask

  task automatic write_entry(input logic [1:0] a, input logic [16:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    clk_step();
    wr_en = 1'b0;
  endtask

  task automatic write_pat();
    write_entry(2'd0, 17'h00100);
    write_entry(2'd1, 17'h10000);
    write_entry(2'd2, 17'h00300);
    write_entry(2'd3, 17'h00400);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    clk_step();
    start = 1'b0;
    cyc = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gate"}, gate, 0);
    chk({tag, "_inc"}, phase_inc, 0);
    chk({tag, "_amp"}, amp, 0);
    chk({tag, "_step"}, step, 0);
    chk({tag, "_pulse"}, step_pulse, 0);
    chk({tag, "_run"}, running, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0; amp_max = 10'd1000;
    repeat (3) clk_step();
    chk_all_zero("rst");
    rst_n = 1'b1;
    clk_step();

    // Main pattern playback with attack/release on step 0.
    write_pat();
    pulse_start();
    chk("a0_pulse", step_pulse, 1);
    chk("a0_run", running, 1);
    chk("a0_gate", gate, 1);
    chk("a0_inc", phase_inc, 'h100);
    chk("a0_amp", amp, 0);
    for (int k = 1; k <= 40; k++) begin
      int sd, tk;
      clk_step();
      sd = (k / 10) % 4;
      tk = k % 10;
      chk("a_step", step, sd);
      chk("a_pulse", step_pulse, tk == 0);
      chk("a_gate", gate, (tk < 8) && (sd != 1));
      chk("a_inc", phase_inc, inc_tab[sd]);
      chk("a_run", running, 1);
      if (k <= 20) chk("a_amp", amp, amp_tab[k]);
    end

    // Write to the current step takes effect only on its next visit.
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 17'h00500;
    clk_step();
    wr_en = 1'b0;
    chk("w_inc_now", phase_inc, 'h100);
    run_to(79);
    chk("w_step3", step, 3);
    chk("w_inc3", phase_inc, 'h400);
    run_to(80);
    chk("w_step0", step, 0);
    chk("w_pulse0", step_pulse, 1);
    chk("w_inc_new", phase_inc, 'h500);

    // Write coinciding with the fetch of that entry is forwarded.
    run_to(89);
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 17'h00600;
    clk_step();
    wr_en = 1'b0;
    chk("byp_step", step, 1);
    chk("byp_inc", phase_inc, 'h600);
    chk("byp_gate", gate, 1);

    // Asynchronous reset mid-step.
    run_to(93);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("mid_rst");
    clk_step();
    rst_n = 1'b1;
    clk_step();
    pulse_start();
    chk("rr_run", running, 1);
    chk("rr_pulse", step_pulse, 1);
    chk("rr_gate", gate, 0);
    chk("rr_inc", phase_inc, 0);

    // amp_max lowered in HOLD, retrigger during release.
    write_pat();
    pulse_start();
    run_to(5);
    chk("b_amp_hold", amp, 1000);
    amp_max = 10'd500;
    run_to(6);
    chk("b_amp_clamp", amp, 500);
    run_to(10);
    start = 1'b1;
    clk_step();
    start = 1'b0;
    chk("b_amp_rel", amp, 244);
    chk("b_restart_pulse", step_pulse, 1);
    run_to(12);
    chk("b_amp_retrig", amp, 244);
    run_to(13);
    chk("b_amp_atk", amp, 500);

    // start and stop together while playing: stop wins.
    run_to(33);
    chk("c_step", step, 2);
    chk("c_amp_pre", amp, 256);
    start = 1'b1; stop = 1'b1;
    clk_step();
    start = 1'b0; stop = 1'b0;
    chk("c_run", running, 0);
    chk("c_gate", gate, 0);
    chk("c_step_hold", step, 2);
    chk("c_pulse", step_pulse, 0);
    chk("c_inc_hold", phase_inc, 'h300);
    chk("c_amp", amp, 500);
    run_to(36);
    chk("c_amp_rel", amp, 372);
    run_to(40);
    chk("c_amp_off", amp, 0);
    chk("c_step_idle", step, 2);
    chk("c_run_idle", running, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
